bot_upd_sched: RTL and testbench

Periodic scheduler for the bot-status path into the PicoBlaze I/O interface.
- Each update period it takes a coherent snapshot of the six bot registers from the simulator: locx, locy, botinfo, sensors, lmdist, rmdist.
- It then pulses upd_sysregs, which raises the PicoBlaze interrupt.
- It holds off the next update until interrupt_ack, or until a timeout expires.
- It counts dropped periods (overruns) and flags timeouts for firmware/debug LEDs.

---
 rtl/bot_pkg.sv | 25 ++
 rtl/upd_period_timer.sv | 34 +++
 rtl/bot_upd_sched.sv | 130 +++++++++++++
 tb/tb_bot_upd_sched.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bot_pkg.sv
// Shared definitions for the bot-status update scheduler: FSM encoding,
// default timing constants and the snapshot record layout.
package bot_pkg;

  localparam int BOT_W               = 8;
  localparam int UPD_PERIOD_DEFAULT  = 5000000;
  localparam int ACK_TIMEOUT_DEFAULT = 1000000;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CAPTURE  = 2'd1,
    ST_ISSUE    = 2'd2,
    ST_WAIT_ACK = 2'd3
  } state_e;

  typedef struct packed {
    logic [BOT_W-1:0] locx;
    logic [BOT_W-1:0] locy;
    logic [BOT_W-1:0] botinfo;
    logic [BOT_W-1:0] sensors;
    logic [BOT_W-1:0] lmdist;
    logic [BOT_W-1:0] rmdist;
  } bot_snap_t;

endpackage

// File: rtl/upd_period_timer.sv
// Free-running period counter 0..PERIOD-1; tick is high combinationally on the
// last count while enabled. Disabling parks the counter at 0.
module upd_period_timer #(
  parameter int PERIOD = 10
) (
  input  logic sysclk,
  input  logic sysreset,
  input  logic en,
  output logic tick
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam logic [CW-1:0] LAST = CW'(PERIOD - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  always_comb begin
    cnt_d = '0;
    if (en && !tick) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/bot_upd_sched.sv
// Periodic bot-status scheduler: snapshots the six simulator registers,
// pulses upd_sysregs, then waits for the interrupt ack or a timeout.
module bot_upd_sched
  import bot_pkg::*;
#(
  parameter int UPD_PERIOD  = UPD_PERIOD_DEFAULT,
  parameter int ACK_TIMEOUT = ACK_TIMEOUT_DEFAULT
) (
  input  logic        sysclk,
  input  logic        sysreset,
  input  logic        sched_en,
  input  logic        bot_busy,
  input  logic [7:0]  bot_locx,
  input  logic [7:0]  bot_locy,
  input  logic [7:0]  bot_info,
  input  logic [7:0]  bot_sensors,
  input  logic [7:0]  bot_lmdist,
  input  logic [7:0]  bot_rmdist,
  input  logic        interrupt_ack,
  input  logic        clr_err,
  output logic [7:0]  locx,
  output logic [7:0]  locy,
  output logic [7:0]  botinfo,
  output logic [7:0]  sensors,
  output logic [7:0]  lmdist,
  output logic [7:0]  rmdist,
  output logic        upd_sysregs,
  output logic [7:0]  overrun_cnt,
  output logic        timeout_err,
  output logic [15:0] upd_cnt
);

  localparam int TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
  localparam logic [TW-1:0] ACK_LAST = TW'(ACK_TIMEOUT - 1);

  state_e        state_q, state_d;
  logic [TW-1:0] ack_tmr_q, ack_tmr_d;
  bot_snap_t     snap_q, snap_d;
  logic [15:0]   upd_cnt_q, upd_cnt_d;
  logic [7:0]    overrun_q, overrun_d;
  logic          timeout_err_q, timeout_err_d;
  logic          tick;
  logic          timeout_hit;

  upd_period_timer #(
    .PERIOD (UPD_PERIOD)
  ) u_timer (
    .sysclk   (sysclk),
    .sysreset (sysreset),
    .en       (sched_en),
    .tick     (tick)
  );

  always_comb begin
    state_d     = state_q;
    ack_tmr_d   = ack_tmr_q;
    snap_d      = snap_q;
    upd_cnt_d   = upd_cnt_q;
    timeout_hit = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (tick) state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        if (!bot_busy) begin
          snap_d  = '{locx: bot_locx, locy: bot_locy, botinfo: bot_info,
                      sensors: bot_sensors, lmdist: bot_lmdist, rmdist: bot_rmdist};
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        upd_cnt_d = upd_cnt_q + 16'd1;
        ack_tmr_d = '0;
        state_d   = ST_WAIT_ACK;
      end
      ST_WAIT_ACK: begin
        // An ack on the last timer cycle is checked first, so it suppresses the error.
        if (interrupt_ack) begin
          state_d = ST_IDLE;
        end else if (ack_tmr_q == ACK_LAST) begin
          timeout_hit = 1'b1;
          state_d     = ST_IDLE;
        end else begin
          ack_tmr_d = ack_tmr_q + TW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    overrun_d = overrun_q;
    if (clr_err) begin
      overrun_d = '0;
    end else if (tick && (state_q != ST_IDLE) && (overrun_q != 8'hFF)) begin
      overrun_d = overrun_q + 8'd1;
    end
    timeout_err_d = timeout_hit | (timeout_err_q & ~clr_err);
  end

  always_ff @(posedge sysclk or negedge sysreset) begin
    if (!sysreset) begin
      state_q       <= ST_IDLE;
      ack_tmr_q     <= '0;
      snap_q        <= '0;
      upd_cnt_q     <= '0;
      overrun_q     <= '0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ack_tmr_q     <= ack_tmr_d;
      snap_q        <= snap_d;
      upd_cnt_q     <= upd_cnt_d;
      overrun_q     <= overrun_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign upd_sysregs = (state_q == ST_ISSUE);
  assign locx        = snap_q.locx;
  assign locy        = snap_q.locy;
  assign botinfo     = snap_q.botinfo;
  assign sensors     = snap_q.sensors;
  assign lmdist      = snap_q.lmdist;
  assign rmdist      = snap_q.rmdist;
  assign upd_cnt     = upd_cnt_q;
  assign overrun_cnt = overrun_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_bot_upd_sched.sv
// Randomized + directed bench for bot_upd_sched: a behavioural model predicts
// each update pulse into a scoreboard queue, a monitor pops and compares.
module tb_bot_upd_sched;

  localparam int P  = 10;
  localparam int TO = 8;

  logic        sysclk = 1'b0;
  logic        sysreset = 1'b0;
  logic        sched_en = 1'b0;
  logic        bot_busy = 1'b0;
  logic [7:0]  bot_locx = '0, bot_locy = '0, bot_info = '0;
  logic [7:0]  bot_sensors = '0, bot_lmdist = '0, bot_rmdist = '0;
  logic        interrupt_ack = 1'b0;
  logic        clr_err = 1'b0;
  logic [7:0]  locx, locy, botinfo, sensors, lmdist, rmdist;
  logic        upd_sysregs;
  logic [7:0]  overrun_cnt;
  logic        timeout_err;
  logic [15:0] upd_cnt;

  bot_upd_sched #(
    .UPD_PERIOD  (P),
    .ACK_TIMEOUT (TO)
  ) dut (
    .sysclk        (sysclk),
    .sysreset      (sysreset),
    .sched_en      (sched_en),
    .bot_busy      (bot_busy),
    .bot_locx      (bot_locx),
    .bot_locy      (bot_locy),
    .bot_info      (bot_info),
    .bot_sensors   (bot_sensors),
    .bot_lmdist    (bot_lmdist),
    .bot_rmdist    (bot_rmdist),
    .interrupt_ack (interrupt_ack),
    .clr_err       (clr_err),
    .locx          (locx),
    .locy          (locy),
    .botinfo       (botinfo),
    .sensors       (sensors),
    .lmdist        (lmdist),
    .rmdist        (rmdist),
    .upd_sysregs   (upd_sysregs),
    .overrun_cnt   (overrun_cnt),
    .timeout_err   (timeout_err),
    .upd_cnt       (upd_cnt)
  );

  always #5 sysclk = ~sysclk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          cyc;
    logic [47:0] snap;
    logic [15:0] upd;
  } exp_t;
  exp_t exp_q[$];

  // Reference model state: "in a sequence", "still needs a snapshot",
  // "pulse due", and how many ack-wait cycles have elapsed.
  int          cyc = 0;
  int          m_cnt = 0;
  bit          m_active = 0;
  bit          m_need_cap = 0;
  bit          m_pulse_due = 0;
  int          m_waited = 0;
  logic [47:0] m_snap = '0;
  logic [15:0] m_upd = '0;
  int          m_ovr = 0;
  bit          m_tmo = 0;
  int          pulse_cyc = 0;

  function automatic void chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  function automatic logic [47:0] dut_snap();
    return {locx, locy, botinfo, sensors, lmdist, rmdist};
  endfunction

  // Behavioural model, evaluated on every clock edge and on reset assertion.
  initial forever begin
    bit tick, to_set;
    @(posedge sysclk or negedge sysreset);
    if (!sysreset) begin
      m_cnt = 0; m_active = 0; m_need_cap = 0; m_pulse_due = 0; m_waited = 0;
      m_snap = '0; m_upd = '0; m_ovr = 0; m_tmo = 0;
      exp_q.delete();
    end else begin
      cyc++;
      tick   = sched_en && (m_cnt == P - 1);
      m_cnt  = sched_en ? (m_cnt + 1) % P : 0;
      to_set = 0;
      if (clr_err) m_ovr = 0;
      else if (tick && m_active && m_ovr < 255) m_ovr = m_ovr + 1;
      if (!m_active) begin
        if (tick) begin
          m_active   = 1;
          m_need_cap = 1;
        end
      end else if (m_need_cap) begin
        if (!bot_busy) begin
          m_snap      = {bot_locx, bot_locy, bot_info, bot_sensors, bot_lmdist, bot_rmdist};
          m_need_cap  = 0;
          m_pulse_due = 1;
          exp_q.push_back('{cyc: cyc, snap: m_snap, upd: m_upd});
        end
      end else if (m_pulse_due) begin
        m_pulse_due = 0;
        m_upd       = m_upd + 16'd1;
        m_waited    = 0;
      end else begin
        m_waited++;
        if (interrupt_ack) m_active = 0;
        else if (m_waited == TO) begin
          to_set   = 1;
          m_active = 0;
        end
      end
      if (to_set) m_tmo = 1;
      else if (clr_err) m_tmo = 0;
    end
  end

  // Monitor: pops the scoreboard on every pulse and tracks the sticky outputs.
  initial forever begin
    @(negedge sysclk);
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      checks++; errors++;
      $display("FAIL pulse_missing: got none expected pulse at cycle %0d", exp_q[0].cyc);
      void'(exp_q.pop_front());
    end
    if (upd_sysregs) begin
      if (exp_q.size() == 0 || exp_q[0].cyc != cyc) begin
        checks++; errors++;
        $display("FAIL pulse_unexpected: got upd_sysregs=1 expected 0 (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        pulse_cyc = cyc;
        chk("pulse_snapshot", 64'(dut_snap()), 64'(e.snap));
        chk("pulse_upd_cnt", 64'(upd_cnt), 64'(e.upd));
        $display("pulse cycle=%0d upd_cnt=%04h snapshot=%012h", cyc, upd_cnt, dut_snap());
      end
    end
    chk("upd_cnt", 64'(upd_cnt), 64'(m_upd));
    chk("overrun_cnt", 64'(overrun_cnt), 64'(m_ovr));
    chk("timeout_err", 64'(timeout_err), 64'(m_tmo));
    chk("snapshot", 64'(dut_snap()), 64'(m_snap));
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge sysclk);
  endtask

  task automatic wait_pulse(string name);
    for (int i = 0; i < 200; i++) begin
      step();
      if (upd_sysregs) return;
    end
    checks++; errors++;
    $display("FAIL %s: got no upd_sysregs expected a pulse within 200 cycles", name);
  endtask

  task automatic wait_tick(string name);
    for (int i = 0; i < 4 * P; i++) begin
      step();
      if (sched_en && m_cnt == P - 1) return;
    end
    checks++; errors++;
    $display("FAIL %s: got no tick expected one within %0d cycles", name, 4 * P);
  endtask

  task automatic wait_idle(string name);
    for (int i = 0; i < 200; i++) begin
      step();
      if (!m_active) return;
    end
    checks++; errors++;
    $display("FAIL %s: got busy sequence expected idle within 200 cycles", name);
  endtask

  task automatic ack_after(int n);
    repeat (n) step();
    interrupt_ack = 1'b1;
    step();
    interrupt_ack = 1'b0;
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
  endtask

  initial begin
    int c0;
    repeat (3) step();
    chk("reset_upd_sysregs", 64'(upd_sysregs), 64'(0));
    chk("reset_snapshot", 64'(dut_snap()), 64'(0));
    chk("reset_counts", 64'({upd_cnt, overrun_cnt, timeout_err}), 64'(0));
    sysreset = 1'b1;

    // Basic update with known locx/rmdist.
    step();
    bot_locx = 8'h12; bot_rmdist = 8'hA5;
    bot_locy = 8'($urandom); bot_info = 8'($urandom);
    bot_sensors = 8'($urandom); bot_lmdist = 8'($urandom);
    sched_en = 1'b1;
    c0 = cyc;
    wait_pulse("s1_pulse");
    chk("s1_latency", 64'(cyc - c0), 64'(11));
    chk("s1_locx", 64'(locx), 64'(8'h12));
    chk("s1_rmdist", 64'(rmdist), 64'(8'hA5));
    ack_after(2);
    chk("s1_upd_cnt", 64'(upd_cnt), 64'(1));

    // Busy stall of 5 cycles with bot_locy changing.
    wait_idle("s2_idle");
    wait_tick("s2_tick");
    c0 = cyc;
    for (int i = 0; i < 5; i++) begin
      step();
      bot_busy = 1'b1;
      bot_locy = 8'($urandom);
    end
    step();
    bot_busy = 1'b0;
    bot_locy = 8'h5C;
    wait_pulse("s2_pulse");
    chk("s2_latency", 64'(cyc - c0), 64'(7));
    chk("s2_locy", 64'(locy), 64'(8'h5C));
    ack_after(1);

    // Ack timeout, then an ack exactly in the final wait cycle.
    wait_idle("s3_idle");
    wait_pulse("s3_pulse");
    c0 = cyc;
    for (int i = 0; i < 20 && !timeout_err; i++) step();
    chk("s3_timeout_delay", 64'(cyc - c0), 64'(TO + 1));
    wait_pulse("s3_next_pulse");
    ack_after(1);
    chk("s3_sticky", 64'(timeout_err), 64'(1));
    pulse_clr();
    chk("s3_cleared", 64'(timeout_err), 64'(0));
    wait_pulse("s3_late_ack_pulse");
    ack_after(TO);
    repeat (3) step();
    chk("s3_late_ack_no_err", 64'(timeout_err), 64'(0));

    // Overruns: two drops, then saturation and clear.
    wait_idle("s4_idle");
    pulse_clr();
    wait_tick("s4_tick");
    for (int i = 0; i < 25; i++) begin
      step();
      bot_busy = 1'b1;
    end
    step();
    bot_busy = 1'b0;
    chk("s4_two_drops", 64'(overrun_cnt), 64'(2));
    wait_pulse("s4_pulse");
    ack_after(1);
    wait_tick("s4_sat_tick");
    bot_busy = 1'b1;
    repeat (3010) step();
    chk("s4_saturate", 64'(overrun_cnt), 64'(255));
    pulse_clr();
    chk("s4_clr_overrun", 64'(overrun_cnt), 64'(0));
    chk("s4_clr_timeout", 64'(timeout_err), 64'(0));
    bot_busy = 1'b0;
    wait_pulse("s4_sat_pulse");
    ack_after(1);

    // Disabled scheduler, then upd_cnt wrap from a preloaded 0xFFFF.
    wait_idle("s5_idle");
    sched_en = 1'b0;
    c0 = pulse_cyc;
    repeat (30) step();
    chk("s5_no_pulse", 64'(pulse_cyc), 64'(c0));
    @(posedge sysclk);
    #1;
    force dut.upd_cnt_q = 16'hFFFF;
    m_upd = 16'hFFFF;
    step();
    release dut.upd_cnt_q;
    step();
    c0 = cyc;
    sched_en = 1'b1;
    wait_pulse("s6_pulse");
    chk("s5_reenable_latency", 64'(cyc - c0), 64'(11));
    ack_after(1);
    chk("s6_wrap", 64'(upd_cnt), 64'(16'h0000));

    // Asynchronous reset while waiting for the ack.
    wait_pulse("s5_rst_pulse");
    step();
    @(posedge sysclk);
    #2;
    sysreset = 1'b0;
    #1;
    chk("rst_upd_sysregs", 64'(upd_sysregs), 64'(0));
    chk("rst_snapshot", 64'(dut_snap()), 64'(0));
    chk("rst_counts", 64'({upd_cnt, overrun_cnt, timeout_err}), 64'(0));
    repeat (3) step();
    sysreset = 1'b1;
    repeat (5) step();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      step();
      bot_locx = 8'($urandom); bot_locy = 8'($urandom); bot_info = 8'($urandom);
      bot_sensors = 8'($urandom); bot_lmdist = 8'($urandom); bot_rmdist = 8'($urandom);
      bot_busy      = ($urandom_range(0, 99) < 25);
      interrupt_ack = ($urandom_range(0, 99) < 30);
      clr_err       = ($urandom_range(0, 99) < 3);
      sched_en      = ($urandom_range(0, 99) < 97);
    end
    step();
    bot_busy = 1'b0; interrupt_ack = 1'b0; clr_err = 1'b0; sched_en = 1'b0;
    for (int i = 0; i < 100 && (m_active || exp_q.size() > 0); i++) begin
      step();
      interrupt_ack = 1'b1;
    end
    interrupt_ack = 1'b0;
    repeat (3) step();
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
